// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM encoding, the nibble
// width and the helper that sizes the nibble index.
package nibble_serial_subtractor_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width for WIDTH/NIBBLE slices; WIDTH >= 8 keeps this at least 1.
    function automatic int idx_width(input int width);
        return $clog2(width / NIBBLE);
    endfunction

endpackage

// File: rtl/nibble_serial_subtractor_borrow_lookahead4.sv
// Four-bit subtract slice: d = a - b - bin, with every borrow formed as a flat
// sum of generate/propagate products so no borrow waits on another.
module borrow_lookahead4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] d,
    output logic       bout
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [3:0] bi_s;

    assign g_s = ~a & b;
    assign p_s = ~(a ^ b);

    assign bi_s[0] = bin;
    assign bi_s[1] = g_s[0] | (p_s[0] & bin);
    assign bi_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & bin);
    assign bi_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                   | (p_s[2] & p_s[1] & p_s[0] & bin);
    assign bout    = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                   | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                   | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & bin);

    assign d = a ^ b ^ bi_s;

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Serial a - b, one nibble per cycle through a borrow-lookahead slice; flags
// are registered on the last nibble and held until the next accepted start.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NNIB = WIDTH / NIBBLE;
    localparam int IDXW = idx_width(WIDTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NNIB - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              borrow_q, borrow_d;
    logic              borrow_out_q, borrow_out_d;
    logic              overflow_q, overflow_d;
    logic              zero_q, zero_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [NIBBLE-1:0] nib_a_s;
    logic [NIBBLE-1:0] nib_b_s;
    logic [NIBBLE-1:0] nib_d_s;
    logic              nib_bout_s;
    logic [WIDTH-1:0]  diff_ins_s;

    assign nib_a_s = a_q[NIBBLE*idx_q +: NIBBLE];
    assign nib_b_s = b_q[NIBBLE*idx_q +: NIBBLE];

    borrow_lookahead4 u_slice (
        .a    (nib_a_s),
        .b    (nib_b_s),
        .bin  (borrow_q),
        .d    (nib_d_s),
        .bout (nib_bout_s)
    );

    // Current diff with this cycle's nibble merged in, so the final flags see the whole result.
    always_comb begin
        diff_ins_s = diff_q;
        diff_ins_s[NIBBLE*idx_q +: NIBBLE] = nib_d_s;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        diff_d       = diff_q;
        idx_d        = idx_q;
        borrow_d     = borrow_q;
        borrow_out_d = borrow_out_q;
        overflow_d   = overflow_q;
        zero_d       = zero_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = 1'b0;
                    idx_d    = '0;
                    state_d  = RUN;
                end else begin
                    state_d  = IDLE;
                end
            end
            RUN: begin
                diff_d   = diff_ins_s;
                borrow_d = nib_bout_s;
                if (idx_q == LAST_IDX) begin
                    idx_d        = '0;
                    borrow_out_d = nib_bout_s;
                    overflow_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                   (diff_ins_s[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d       = (diff_ins_s == '0);
                    state_d      = DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            diff_q       <= '0;
            idx_q        <= '0;
            borrow_q     <= 1'b0;
            borrow_out_q <= 1'b0;
            overflow_q   <= 1'b0;
            zero_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            diff_q       <= diff_d;
            idx_q        <= idx_d;
            borrow_q     <= borrow_d;
            borrow_out_q <= borrow_out_d;
            overflow_q   <= overflow_d;
            zero_q       <= zero_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
    assign overflow   = overflow_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench: directed scenarios plus randomized back-to-back
// operations compared against plain-arithmetic expectations.
module tb_nibble_serial_subtractor;

    localparam int WIDTH = 32;
    localparam int NNIB  = WIDTH / 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_done_cyc = 0;

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .zero       (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and check it at the done cycle; returns in the done cycle.
    // exp_acc: edges until acceptance; poke_at: RUN cycle for a stray start (-1 = none).
    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input int exp_acc, input int poke_at);
        int n;
        int lat;
        int busy_cnt;
        logic [31:0] exp_diff;
        logic        exp_brw;
        logic        exp_ovf;
        longint      sres;
        exp_diff = av - bv;
        exp_brw  = (av < bv);
        sres     = longint'($signed(av)) - longint'($signed(bv));
        exp_ovf  = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        start = 1'b1;
        a = av;
        b = bv;
        n = 0;
        do begin
            tick();
            n++;
        end while (!busy && n < 4);
        chk({tag, "_accept"}, n, exp_acc);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        busy_cnt = 1;
        while (!done && lat < 20) begin
            if (lat == poke_at) begin
                start = 1'b1;
                a = $urandom;
                b = $urandom;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, NNIB);
        chk({tag, "_busy_cycles"}, busy_cnt, NNIB);
        chk({tag, "_diff"}, diff, exp_diff);
        chk({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, exp_brw});
        chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp_diff == 32'd0)});
        last_done_cyc = cyc;
    endtask

    // Cycle after done: done must drop and the result must hold.
    task automatic after_done(input string tag, input logic [31:0] exp_diff);
        tick();
        chk({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
        chk({tag, "_hold"}, diff, exp_diff);
    endtask

    initial begin
        int extra;
        int prev;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        tick();
        tick();
        chk("reset_outputs", {26'd0, busy, done, borrow_out, overflow, zero, 1'b0}, 32'd0);
        chk("reset_diff", diff, 32'd0);
        reset = 1'b0;

        run_op("sub_5_3", 32'd5, 32'd3, 1, -1);
        chk("sub_5_3_const", diff, 32'h0000_0002);
        after_done("sub_5_3", 32'h0000_0002);

        run_op("sub_0_1", 32'd0, 32'd1, 1, -1);
        chk("sub_0_1_const", {diff[30:0], borrow_out}, {31'h7FFF_FFFF, 1'b1});
        after_done("sub_0_1", 32'hFFFF_FFFF);

        run_op("ovf_neg", 32'h8000_0000, 32'h0000_0001, 1, -1);
        chk("ovf_neg_const", {diff[30:0], overflow}, {31'h7FFF_FFFF, 1'b1});
        after_done("ovf_neg", 32'h7FFF_FFFF);

        run_op("ovf_pos", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, -1);
        chk("ovf_pos_const", {borrow_out, overflow}, 32'd3);
        after_done("ovf_pos", 32'h8000_0000);

        // Equal operands, with a stray start three cycles into RUN.
        run_op("equal", 32'h1234_5678, 32'h1234_5678, 1, 3);
        chk("equal_zero_const", {31'd0, zero}, 32'd1);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) extra++;
        end
        chk("equal_no_second_op", extra, 0);
        chk("equal_result_kept", diff, 32'd0);

        // Start in the done cycle is ignored, then accepted the following cycle.
        run_op("pre_dc", 32'd9, 32'd4, 1, -1);
        run_op("start_in_done", 32'd100, 32'd1, 2, -1);
        after_done("start_in_done", 32'd99);

        // Reset during RUN cycle 4 aborts without done.
        start = 1'b1;
        a = 32'hFFFF_FFFF;
        b = 32'h0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        tick();
        chk("abort_outputs", {26'd0, busy, done, borrow_out, overflow, zero, 1'b0}, 32'd0);
        chk("abort_diff", diff, 32'd0);
        reset = 1'b0;
        run_op("post_reset", 32'h10, 32'h01, 1, -1);
        chk("post_reset_const", diff, 32'h0F);
        after_done("post_reset", 32'h0F);

        // Random back-to-back: each new start raised in the cycle after done.
        run_op("rnd_first", $urandom, $urandom, 1, -1);
        for (int i = 0; i < 2000; i++) begin
            prev = last_done_cyc;
            tick();
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) ra = 32'h8000_0000 ^ (ra & 32'h0000_00FF);
            run_op("rnd", ra, rb, 1, -1);
            chk("rnd_spacing", last_done_cyc - prev, NNIB + 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
